aggr_scheduler: RTL and testbench
=================================

AGGR_SCHEDULER -- requirements
Module: aggr_scheduler

Interface
REQ-001 The block SHALL have parameter TOTAL_NODES, default 13264, which is the Wh BRAM depth in entries.
REQ-002 The block SHALL have parameter NUM_SUBGRAPHS, default 2708, which is the number of subgraphs per run.
REQ-003 The block SHALL have parameter MAX_NODES, default 168, which is the maximum number of nodes per subgraph; NN_W = $clog2(MAX_NODES)+1.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- start_i  in  1  run-start pulse.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle end-of-run pulse.
- nn_vld_i / nn_rdy_o  in / out  1  per-subgraph node-count descriptor handshake.
- nn_i  in  NN_W  node count of the next subgraph.
- alpha_ff_empty  in  1  alpha FIFO empty.
- alpha_ff_rd_vld  out  1  alpha FIFO pop.
- wh_bram_addrb  out  $clog2(TOTAL_NODES)  Wh read address.
- dst_rdy_i  in  1  aggregator can accept a beat.
- mac_vld_o  out  1  beat valid, aligned with Wh BRAM data.
- mac_first_o  out  1  first node of the subgraph.
- mac_last_o  out  1  last node of the subgraph.
- sg_idx_o  out  $clog2(NUM_SUBGRAPHS)  subgraph index of the beat.
- err_o  out  1  sticky error flag.
- stall_alpha_o  out  32  count of cycles stalled on alpha FIFO empty.
- stall_dst_o  out  32  count of cycles stalled on dst_rdy_i low.

Function
REQ-005 The FSM SHALL have the states IDLE, LOAD, RUN, DRAIN and DONE.
REQ-006 In IDLE, start_i SHALL move the FSM to LOAD next cycle and clear the address, subgraph count and err_o; start_i SHALL be ignored in every other state.
REQ-007 In LOAD, nn_rdy_o SHALL be 1; on nn_vld_i && nn_rdy_o the block SHALL latch nn_i, clear the node count and go to RUN.
REQ-008 In LOAD, a descriptor with nn_i == 0 SHALL be consumed with no beats, SHALL set err_o, and SHALL advance the subgraph count as a normal subgraph end.
REQ-009 The block SHALL issue in RUN when !alpha_ff_empty && dst_rdy_i; alpha_ff_rd_vld SHALL equal the issue condition (combinational).
REQ-010 wh_bram_addrb SHALL be a register that increments by 1 after each issue; at TOTAL_NODES-1 it SHALL wrap to 0 and set err_o.
REQ-011 mac_vld_o, mac_first_o, mac_last_o and sg_idx_o SHALL be registered one cycle after issue, matching the one-cycle BRAM read latency.
REQ-012 mac_first_o SHALL be 1 when the issued node count is 0; mac_last_o SHALL be 1 when the node count is the latched nn-1.
REQ-013 After issuing a last beat, the FSM SHALL go to LOAD, or to DRAIN if the subgraph count is NUM_SUBGRAPHS-1.
REQ-014 DRAIN SHALL last exactly 1 cycle, so the final beat is emitted; DONE SHALL assert done_o for 1 cycle and then return to IDLE.
REQ-015 busy_o SHALL be 1 in every state except IDLE.
REQ-016 In RUN, a stall on alpha_ff_empty SHALL take precedence in counting; with both stall causes present, only stall_alpha_o SHALL increment.

Reset
REQ-017 On rst_n low, the FSM SHALL enter IDLE immediately, including mid-run.
REQ-018 On reset, every registered output and counter SHALL be 0, with nn_rdy_o=0 and alpha_ff_rd_vld=0.
REQ-019 After reset, no beat SHALL be emitted until a new start_i.

Configuration
REQ-020 With AGGR_SCHED_PERF_EN defined, stall_alpha_o and stall_dst_o SHALL count per REQ-016, clear on start_i, and saturate at 2^32-1.
REQ-021 Without AGGR_SCHED_PERF_EN, both stall ports SHALL be constant 0 and no counter logic SHALL be synthesised.

Structure
REQ-022 The state enum and the NN_W and width derivations SHALL live in shared package gat_pkg.
REQ-023 The stall counters SHALL live in sub-module aggr_sched_perf_cnt, instantiated only under AGGR_SCHED_PERF_EN.

Verification
REQ-024 Scenario: NUM_SUBGRAPHS=2, nn={3,2}, alpha FIFO never empty, dst_rdy_i=1 -> 5 beats on consecutive cycles, addresses 0..4, first on beats 0 and 3, last on beats 2 and 4, sg_idx 0,0,0,1,1, done_o 2 cycles after the final issue.
REQ-025 Scenario: alpha_ff_empty high for 4 cycles mid-subgraph -> no pop and no beat in those cycles, stall_alpha_o=4 (macro on), address held.
REQ-026 Scenario: nn=0 for subgraph 0 -> err_o=1, no beats for that subgraph, subgraph 1 beats carry sg_idx 1.
REQ-027 Scenario: TOTAL_NODES=4 with 6 total nodes -> address sequence 0,1,2,3,0,1 and err_o set at the wrap.
REQ-028 Scenario: rst_n asserted in RUN -> all outputs 0 within the same cycle, start_i ignored while busy, a restart after reset begins at address 0.

Source files
------------

// File: rtl/gat_pkg.sv
// gat_pkg: shared FSM state type and width helpers for the aggregation scheduler
package gat_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} sched_state_e;
  function automatic int nn_width(input int max_nodes);
    return $clog2(max_nodes) + 1;
  endfunction
  function automatic int idx_width(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/aggr_sched_perf_cnt.sv
// aggr_sched_perf_cnt: saturating stall counters (alpha FIFO empty, destination not ready)
//   clk, rst_n               clock, async active-low reset
//   clr_i                    clear both counters (accepted run start)
//   stall_alpha_i/_dst_i     one-cycle stall indications
//   stall_alpha_o/_dst_o     32-bit counts, saturating at all-ones
module aggr_sched_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        stall_alpha_i,
  input  logic        stall_dst_i,
  output logic [31:0] stall_alpha_o,
  output logic [31:0] stall_dst_o
);
  logic [31:0] alpha_q, dst_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alpha_q <= '0;
      dst_q   <= '0;
    end else begin
      alpha_q <= clr_i ? '0 : alpha_q + 32'(stall_alpha_i && alpha_q != '1);
      dst_q   <= clr_i ? '0 : dst_q + 32'(stall_dst_i && dst_q != '1);
    end
  end
  assign stall_alpha_o = alpha_q;
  assign stall_dst_o   = dst_q;
endmodule

// File: rtl/aggr_scheduler.sv
// aggr_scheduler: walks subgraph node counts, pops alpha FIFO and issues Wh BRAM reads as MAC beats
//   clk, rst_n                      clock, async active-low reset
//   start_i / busy_o / done_o       run control
//   nn_vld_i / nn_rdy_o / nn_i      per-subgraph node-count descriptor
//   alpha_ff_empty / alpha_ff_rd_vld alpha FIFO status / pop
//   wh_bram_addrb                   Wh BRAM read address
//   dst_rdy_i                       aggregator backpressure
//   mac_vld_o/first/last, sg_idx_o  beat, aligned with BRAM read data
//   err_o                           sticky error (zero-node subgraph or address wrap)
//   stall_alpha_o / stall_dst_o     stall counters, live only with AGGR_SCHED_PERF_EN
module aggr_scheduler
  import gat_pkg::*;
#(
  parameter  int TOTAL_NODES   = 13264,
  parameter  int NUM_SUBGRAPHS = 2708,
  parameter  int MAX_NODES     = 168,
  localparam int NN_W          = nn_width(MAX_NODES),
  localparam int AW            = idx_width(TOTAL_NODES),
  localparam int SW            = idx_width(NUM_SUBGRAPHS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  input  logic            nn_vld_i,
  output logic            nn_rdy_o,
  input  logic [NN_W-1:0] nn_i,
  input  logic            alpha_ff_empty,
  output logic            alpha_ff_rd_vld,
  output logic [AW-1:0]   wh_bram_addrb,
  input  logic            dst_rdy_i,
  output logic            mac_vld_o,
  output logic            mac_first_o,
  output logic            mac_last_o,
  output logic [SW-1:0]   sg_idx_o,
  output logic            err_o,
  output logic [31:0]     stall_alpha_o,
  output logic [31:0]     stall_dst_o
);
  sched_state_e    state_q;
  logic [AW-1:0]   addr_q, addr_d;
  logic [SW-1:0]   sg_q, sg_idx_q;
  logic [NN_W-1:0] nn_q, node_q;
  logic            err_q, vld_q, first_q, last_q;
  logic            issue, node_last, sg_last, addr_wrap;
  assign issue     = state_q == S_RUN && !alpha_ff_empty && dst_rdy_i;
  assign node_last = node_q == nn_q - 1'b1;
  assign sg_last   = sg_q == SW'(NUM_SUBGRAPHS - 1);
  assign addr_wrap = addr_q == AW'(TOTAL_NODES - 1);
  assign addr_d    = addr_wrap ? '0 : addr_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      sg_q     <= '0;
      sg_idx_q <= '0;
      nn_q     <= '0;
      node_q   <= '0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      // beat flags trail the issue by one cycle to line up with BRAM read data
      vld_q   <= issue;
      first_q <= issue && node_q == '0;
      last_q  <= issue && node_last;
      if (issue) sg_idx_q <= sg_q;
      case (state_q)
        S_IDLE: if (start_i) begin
          state_q <= S_LOAD;
          addr_q  <= '0;
          sg_q    <= '0;
          err_q   <= 1'b0;
        end
        S_LOAD: if (nn_vld_i) begin
          if (nn_i == '0) begin
            // empty subgraph: flag it and close it out without issuing
            err_q <= 1'b1;
            if (sg_last) state_q <= S_DRAIN;
            else sg_q <= sg_q + 1'b1;
          end else begin
            nn_q    <= nn_i;
            node_q  <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: if (issue) begin
          addr_q <= addr_d;
          if (addr_wrap) err_q <= 1'b1;
          node_q <= node_q + 1'b1;
          if (node_last) begin
            if (sg_last) state_q <= S_DRAIN;
            else begin
              sg_q    <= sg_q + 1'b1;
              state_q <= S_LOAD;
            end
          end
        end
        S_DRAIN: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy_o          = state_q != S_IDLE;
  assign done_o          = state_q == S_DONE;
  assign nn_rdy_o        = state_q == S_LOAD;
  assign alpha_ff_rd_vld = issue;
  assign wh_bram_addrb   = addr_q;
  assign mac_vld_o       = vld_q;
  assign mac_first_o     = first_q;
  assign mac_last_o      = last_q;
  assign sg_idx_o        = sg_idx_q;
  assign err_o           = err_q;
`ifdef AGGR_SCHED_PERF_EN
  // an empty alpha FIFO takes precedence when both stall causes are present
  aggr_sched_perf_cnt u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (state_q == S_IDLE && start_i),
    .stall_alpha_i(state_q == S_RUN && alpha_ff_empty),
    .stall_dst_i  (state_q == S_RUN && !alpha_ff_empty && !dst_rdy_i),
    .stall_alpha_o(stall_alpha_o),
    .stall_dst_o  (stall_dst_o)
  );
`else
  assign stall_alpha_o = '0;
  assign stall_dst_o   = '0;
`endif
endmodule

// File: tb/tb_aggr_scheduler.sv
// tb_aggr_scheduler: table-driven, directed and randomized checks of aggr_scheduler against a transaction-level model
module tb_aggr_scheduler;
  logic clk = 1'b0, rst_n, start, nn_vld, empty, dst;
  logic [3:0] nn;
  logic busy_o, done_o, nn_rdy_o, alpha_ff_rd_vld, mac_vld_o, mac_first_o, mac_last_o, err_o;
  logic [2:0] wh_bram_addrb;
  logic [0:0] sg_idx_o;
  logic [31:0] stall_alpha_o, stall_dst_o;
  logic d4_busy, d4_done, d4_rdy, d4_pop, d4_vld, d4_first, d4_last, err4;
  logic [1:0] addr4;
  logic [0:0] d4_sg;
  logic [31:0] d4_sa, d4_sd;
  logic [11:0] outs;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  aggr_scheduler #(.TOTAL_NODES(8), .NUM_SUBGRAPHS(2), .MAX_NODES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy_o), .done_o(done_o),
    .nn_vld_i(nn_vld), .nn_rdy_o(nn_rdy_o), .nn_i(nn), .alpha_ff_empty(empty),
    .alpha_ff_rd_vld(alpha_ff_rd_vld), .wh_bram_addrb(wh_bram_addrb), .dst_rdy_i(dst),
    .mac_vld_o(mac_vld_o), .mac_first_o(mac_first_o), .mac_last_o(mac_last_o),
    .sg_idx_o(sg_idx_o), .err_o(err_o), .stall_alpha_o(stall_alpha_o), .stall_dst_o(stall_dst_o));

  aggr_scheduler #(.TOTAL_NODES(4), .NUM_SUBGRAPHS(2), .MAX_NODES(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(d4_busy), .done_o(d4_done),
    .nn_vld_i(nn_vld), .nn_rdy_o(d4_rdy), .nn_i(nn), .alpha_ff_empty(empty),
    .alpha_ff_rd_vld(d4_pop), .wh_bram_addrb(addr4), .dst_rdy_i(dst),
    .mac_vld_o(d4_vld), .mac_first_o(d4_first), .mac_last_o(d4_last),
    .sg_idx_o(d4_sg), .err_o(err4), .stall_alpha_o(d4_sa), .stall_dst_o(d4_sd));

  assign outs = {busy_o, nn_rdy_o, alpha_ff_rd_vld, mac_vld_o, mac_first_o, mac_last_o,
                 sg_idx_o, done_o, err_o, wh_bram_addrb};

  typedef struct {logic st; logic nv; logic [3:0] n; logic [11:0] eq;} vec_t;
  typedef struct {logic [2:0] a8; logic [1:0] a4; logic f; logic l; logic sg;} beat_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] eq);
    tests++;
    if (act !== eq) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, eq);
    end
  endtask

  // mode 0: random stimulus, 1: alpha FIFO empty for cycles 4..7, 2: clean flow
  task automatic run(input int n0, input int n1, input int mode);
    int nns[2];
    beat_t q[$];
    int g, di, rem, pi, bi, sa, sd, last_evt, cyc;
    bit zero, done_seen, exp_rdy, pexp, prev_pop;
    nns[0] = n0; nns[1] = n1; g = 0; zero = n0 == 0 || n1 == 0;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < nns[s]; k++) begin
        q.push_back('{a8: 3'(g % 8), a4: 2'(g % 4), f: (k == 0), l: (k == nns[s] - 1), sg: 1'(s)});
        g++;
      end
    di = 0; rem = 0; pi = 0; bi = 0; sa = 0; sd = 0; last_evt = 0; done_seen = 0; prev_pop = 0;
    @(posedge clk); #1;
    start = 1; nn_vld = 0; nn = 0; empty = 0; dst = 1;
    for (cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        start  = (mode == 0) && ($urandom_range(0, 7) == 0);
        empty  = (mode == 0) ? ($urandom_range(0, 3) == 0) : (mode == 1 && cyc >= 4 && cyc < 8);
        dst    = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        nn_vld = di < 2 && (mode != 0 || $urandom_range(0, 1) == 1);
        nn     = di < 2 ? 4'(nns[di]) : 4'd0;
      end
      @(negedge clk);
      exp_rdy = cyc > 0 && rem == 0 && di < 2;
      pexp    = rem > 0 && !empty && dst;
      chk("busy", busy_o, cyc > 0);
      chk("nn_rdy", nn_rdy_o, exp_rdy);
      chk("pop", alpha_ff_rd_vld, pexp);
      chk("mac_vld", mac_vld_o, prev_pop);
      if (prev_pop) begin
        chk("beat_flags", {mac_first_o, mac_last_o, sg_idx_o}, {q[bi].f, q[bi].l, q[bi].sg});
        bi++;
      end
      if (rem > 0) begin
        if (empty) sa++;
        else if (!dst) sd++;
      end
      if (pexp) begin
        chk("addr8", wh_bram_addrb, q[pi].a8);
        chk("addr4", addr4, q[pi].a4);
        pi++; rem--; last_evt = cyc;
      end
      if (exp_rdy && nn_vld) begin
        if (nns[di] == 0) last_evt = cyc;
        else rem = nns[di];
        di++;
      end
      if (done_o) begin
        done_seen = 1;
        chk("done_latency", cyc - last_evt, 2);
      end
      prev_pop = pexp;
    end
    chk("done_seen", done_seen, 1);
    chk("beat_count", bi, q.size());
    chk("err8", err_o, zero || g >= 8);
    chk("err4", err4, zero || g >= 4);
`ifdef AGGR_SCHED_PERF_EN
    chk("stall_alpha", stall_alpha_o, sa);
    chk("stall_dst", stall_dst_o, sd);
`else
    chk("stall_alpha", stall_alpha_o, 0);
    chk("stall_dst", stall_dst_o, 0);
`endif
    @(posedge clk); #1;
    start = 0; nn_vld = 0;
    @(negedge clk);
    chk("idle_after_done", {busy_o, done_o}, 0);
  endtask

  initial begin
    vec_t tbl[11];
    tbl[0]  = '{1, 0, 0, 12'b0_0_0_0_0_0_0_0_0_000};
    tbl[1]  = '{0, 1, 3, 12'b1_1_0_0_0_0_0_0_0_000};
    tbl[2]  = '{0, 0, 0, 12'b1_0_1_0_0_0_0_0_0_000};
    tbl[3]  = '{0, 0, 0, 12'b1_0_1_1_1_0_0_0_0_001};
    tbl[4]  = '{0, 0, 0, 12'b1_0_1_1_0_0_0_0_0_010};
    tbl[5]  = '{0, 1, 2, 12'b1_1_0_1_0_1_0_0_0_011};
    tbl[6]  = '{0, 0, 0, 12'b1_0_1_0_0_0_0_0_0_011};
    tbl[7]  = '{0, 0, 0, 12'b1_0_1_1_1_0_1_0_0_100};
    tbl[8]  = '{0, 0, 0, 12'b1_0_0_1_0_1_1_0_0_101};
    tbl[9]  = '{0, 0, 0, 12'b1_0_0_0_0_0_1_1_0_101};
    tbl[10] = '{0, 0, 0, 12'b0_0_0_0_0_0_1_0_0_101};
    rst_n = 0; start = 0; nn_vld = 0; nn = 0; empty = 1; dst = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs, 0);
    chk("reset_stalls", stall_alpha_o | stall_dst_o, 0);
    rst_n = 1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      start = tbl[i].st; nn_vld = tbl[i].nv; nn = tbl[i].n; empty = 0; dst = 1;
      @(negedge clk);
      chk($sformatf("table_row%0d", i), outs, tbl[i].eq);
    end
    run(6, 1, 1);
`ifdef AGGR_SCHED_PERF_EN
    chk("stall_alpha_four", stall_alpha_o, 4);
`endif
    run(0, 3, 2);
    run(4, 2, 2);
    run(3, 0, 2);
    run(8, 8, 0);
    for (int r = 0; r < 20; r++) run($urandom_range(0, 8), $urandom_range(0, 8), 0);
    @(posedge clk); #1;
    start = 1; empty = 0; dst = 1;
    @(posedge clk); #1;
    start = 0; nn_vld = 1; nn = 5;
    @(posedge clk); #1;
    nn_vld = 0; start = 1;
    repeat (2) @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("mid_run", {busy_o, mac_vld_o, err_o, wh_bram_addrb}, {1'b1, 1'b1, 1'b0, 3'd2});
    #2 rst_n = 0;
    #1;
    chk("async_reset_outs", outs, 0);
    chk("async_reset_stalls", stall_alpha_o | stall_dst_o, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      nn_vld = 1; nn = 2;
      @(negedge clk);
      chk("no_beat_after_reset", {busy_o, mac_vld_o, alpha_ff_rd_vld}, 0);
    end
    nn_vld = 0;
    run(3, 2, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
